// File: rtl/key_debounce_edge_pkg.sv
// rtl/key_debounce_edge_pkg.sv - shared FSM state encodings and debounce defaults
package key_debounce_edge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } db_state_t;

   localparam int DB_CYCLES_DEF = 1000000;
   localparam int CNT_W_DEF     = 20;

endpackage

// File: rtl/key_debounce_edge_if.sv
// rtl/key_debounce_edge_if.sv - key lane bundle: raw pins in, debounced level and pulses out
interface key_debounce_edge_if #(
   parameter int LANES = 4
);
   logic [LANES-1:0] key_raw;
   logic [LANES-1:0] key_level;
   logic [LANES-1:0] key_press;
   logic [LANES-1:0] key_release;
   logic             key_any_press;

   modport master (
      output key_raw,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_any_press
   );

   modport slave (
      input  key_raw,
      output key_level,
      output key_press,
      output key_release,
      output key_any_press
   );
endinterface

// File: rtl/key_debounce_edge_lane.sv
// rtl/key_debounce_edge_lane.sv - one lane: polarity normalise, 2-flop sync, counter and debounce FSM
module key_debounce_edge_lane
   import key_debounce_edge_pkg::*;
#(
   parameter int DB_CYCLES  = DB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int ACTIVE_LOW = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_press_next
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic             POL_INV  = (ACTIVE_LOW != 0);

   db_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             w_norm;
   logic             w_at_last;

   assign w_norm       = i_key_raw ^ POL_INV;
   assign w_at_last    = (r_cnt == CNT_LAST);
   // Exposed early so the top can register its any-press flag in the same cycle as o_press.
   assign o_press_next = (r_state == ST_PRESS_WAIT) && r_s2 && w_at_last;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_s1      <= w_norm;
         r_s2      <= r_s1;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_s2) begin
                  r_state <= ST_PRESS_WAIT;
                  r_cnt   <= '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!r_s2) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else if (w_at_last) begin
                  r_state <= ST_HELD;
                  r_cnt   <= '0;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (!r_s2) begin
                  r_state <= ST_RELEASE_WAIT;
                  r_cnt   <= '0;
               end
            end
            ST_RELEASE_WAIT: begin
               if (r_s2) begin
                  r_state <= ST_HELD;
                  r_cnt   <= '0;
               end else if (w_at_last) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
endmodule

// File: rtl/key_debounce_edge.sv
// rtl/key_debounce_edge.sv - top: LANES independent debounce lanes plus registered any-press flag
module key_debounce_edge
   import key_debounce_edge_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int DB_CYCLES  = DB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   key_debounce_edge_if.slave  bus
);
   logic [LANES-1:0] w_level;
   logic [LANES-1:0] w_press;
   logic [LANES-1:0] w_release;
   logic [LANES-1:0] w_press_next;
   logic             r_any_press;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      key_debounce_edge_lane #(
         .DB_CYCLES  (DB_CYCLES),
         .CNT_W      (CNT_W),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_lane (
         .i_clk        (i_clk),
         .i_rst_n      (i_rst_n),
         .i_key_raw    (bus.key_raw[g]),
         .o_level      (w_level[g]),
         .o_press      (w_press[g]),
         .o_release    (w_release[g]),
         .o_press_next (w_press_next[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_any_press <= 1'b0;
      end else begin
         r_any_press <= |w_press_next;
      end
   end

   assign bus.key_level     = w_level;
   assign bus.key_press     = w_press;
   assign bus.key_release   = w_release;
   assign bus.key_any_press = r_any_press;
endmodule

// File: doc/key_debounce_edge.md
Name: key_debounce_edge

Overview:
- Front-end input stage for the finger-key lanes: takes raw, asynchronous, bouncing push-button inputs.
- Per lane, it synchronises the input, debounces it, and produces a clean registered level plus single-cycle press and release pulses.
- Its outputs feed the D-flip-flop-based state registers and the hit-judge logic directly downstream.
- All lanes are independent and identical.

Parameters:
- LANES, 4, number of key lanes.
- DB_CYCLES, 1000000, consecutive stable synchronised samples required to accept a change (10 ms at 100 MHz); legal range is 2 or more.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DB_CYCLES.
- ACTIVE_LOW, 1, 1 = key_raw low means pressed (board pull-ups); 0 = high means pressed.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_raw  in  LANES  raw asynchronous button pins.
- key_level  out  LANES  debounced level; 1 = pressed, polarity already normalised.
- key_press  out  LANES  one-cycle pulse when a lane becomes debounced-pressed.
- key_release  out  LANES  one-cycle pulse when a lane becomes debounced-released.
- key_any_press  out  1  OR of key_press (registered alongside it, same cycle).

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. There is no asynchronous reset anywhere.
- Polarity:
  - Normalise first: n = key_raw XOR ACTIVE_LOW per lane.
  - Then pass n through a 2-flop synchroniser s1 -> s2.
- Reset (rst_n=0 at a rising edge):
  - s1, s2, counters = 0; every lane FSM = IDLE.
  - key_level, key_press, key_release, key_any_press = 0.
  - Reset wins over every other event, including mid-count or HELD; no pulse is emitted on reset or on its exit.
- Per-lane FSM, 2-bit state, registered:
  - IDLE (level 0): s2=1 -> PRESS_WAIT, cnt=0; else stay.
  - PRESS_WAIT:
    - s2=0 -> IDLE; cnt cleared; no pulse (bounce rejected).
    - s2=1 and cnt<DB_CYCLES-1 -> cnt+1.
    - s2=1 and cnt==DB_CYCLES-1 -> HELD; key_level<=1; key_press<=1 for exactly one cycle.
  - HELD (level 1): s2=0 -> RELEASE_WAIT, cnt=0; else stay.
  - RELEASE_WAIT:
    - s2=1 -> HELD; no pulse.
    - s2=0 and cnt<DB_CYCLES-1 -> cnt+1.
    - s2=0 and cnt==DB_CYCLES-1 -> IDLE; key_level<=0; key_release<=1 for one cycle.
- Latency:
  - A clean press sampled into s1 at edge 0 gives key_press/key_level updated at edge DB_CYCLES+2, i.e. the (DB_CYCLES+3)th edge.
  - Release latency is symmetric.
- Pulse and level rules:
  - key_press and key_release are never high together on one lane.
  - Every press is followed by a release before the next press.
  - key_level only changes in the same cycle as the matching pulse.
- Counter:
  - Saturates by construction, since it never exceeds DB_CYCLES-1; no wrap-around.
  - Cleared on every transition out of a WAIT state.
- Lanes are independent: simultaneous presses on several lanes give simultaneous pulses; key_any_press is high for that one cycle.
- Glitches: any glitch shorter than DB_CYCLES samples is invisible at the outputs.

Decomposition:
- Shared package/header debounce_defs holds:
  - state encodings ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_HELD=2'd2, ST_RELEASE_WAIT=2'd3;
  - the default DB_CYCLES/CNT_W constants.
- Sub-module key_debounce_lane contains one synchroniser, counter and FSM, with 1-bit in and level/press/release out.
- The top generates LANES instances and registers key_any_press.

Test Plan (DB_CYCLES=4, CNT_W=3, ACTIVE_LOW=1, LANES=4):
- Reset: hold rst_n=0 for 3 edges with key_raw=4'b0000 (all pressed) -> all outputs 0 throughout. Release rst_n -> key_press[3:0]=4'b1111 and key_any_press=1 for one cycle at the 7th edge after reset release; key_level=4'b1111 thereafter.
- Clean press on lane 0:
  - Drive key_raw[0] 1->0 held -> key_press[0]=1 for exactly one cycle at the 7th edge; key_level[0]=1.
  - Back to 1 -> key_release[0] pulse 7 edges later; key_level[0]=0.
- Bounce rejection: key_raw[1] toggles low for 3 cycles, high for 1, low for 2, then high -> no key_press[1], key_level[1] stays 0.
- Simultaneous lanes: key_raw 4'b1111 -> 4'b0101 (lanes 1 and 3 pressed) -> key_press=4'b1010 in one cycle, key_any_press=1 once; lanes 0 and 2 silent.
- Reset mid-operation: lane 2 in PRESS_WAIT (2 samples counted) and lane 0 in HELD; assert rst_n=0 for one edge -> key_level=0, no release pulse. After reset with the keys still pressed, a fresh press pulse appears only after the full 7-edge latency.
- Release bounce: lane 0 HELD; key_raw[0] high for 2 cycles, then low -> no key_release[0], key_level[0] stays 1.
